// File: rtl/l2_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : l2_port_arbiter_pkg
//  Description : Shared widths, defaults and types for the L1-to-L2 port
//                arbiter and its round-robin picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package l2_port_arbiter_pkg;

   // Cache datapath widths shared with the L1/L2 cache FSMs
   localparam int ADDRESS_WIDTH          = 32;
   localparam int DATA_WIDTH             = 32;
   localparam int MAIN_MEMORY_DATA_WIDTH = 128;

   // Arbiter defaults
   localparam int NUM_REQ_DEFAULT        = 4;
   localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OP_READ       = 2'd0,
      OP_WRITE      = 2'd1,
      OP_WRITE_BACK = 2'd2
   } l2_op_t;

   // Next requester index after id, wrapping at n
   function automatic int rr_next(input int id, input int n);
      return (id + 1 >= n) ? 0 : id + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_picker
//  Description : Combinational round-robin picker. Starting at rr_ptr_i and
//                wrapping, returns the first active requester index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
   import l2_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEFAULT,
   parameter int IDW     = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] active_i,
   input  logic [IDW-1:0]     rr_ptr_i,
   output logic [IDW-1:0]     winner_o,
   output logic               valid_o
);

   // Walk offsets from the pointer; the first active slot after wrap wins
   always_comb begin
      int              idx;
      logic [IDW-1:0]  idx_b;
      idx      = 0;
      idx_b    = '0;
      winner_o = '0;
      valid_o  = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = int'(rr_ptr_i) + off;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         idx_b = IDW'(idx);
         if (!valid_o && active_i[idx_b]) begin
            valid_o  = 1'b1;
            winner_o = idx_b;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : l2_port_arbiter
//  Description : Shares the single L2 request port between NUM_REQ L1 cache
//                FSMs. Round-robin grant, one transaction in flight, latched
//                request held until L2 completion, one-cycle response pulse
//                routed back to the granted L1 only. Optional WAIT timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_port_arbiter
   import l2_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = NUM_REQ_DEFAULT,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)(
   input  logic                                           clk,
   input  logic                                           rst_n,
   // L1 side
   input  logic [NUM_REQ-1:0]                             l1_read_request_i,
   input  logic [NUM_REQ-1:0]                             l1_write_request_i,
   input  logic [NUM_REQ-1:0]                             l1_write_back_request_i,
   input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]          l1_address_i,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]             l1_write_data_i,
   input  logic [NUM_REQ-1:0][MAIN_MEMORY_DATA_WIDTH-1:0] l1_write_back_data_i,
   output logic [NUM_REQ-1:0]                             l1_L2_ready_o,
   output logic [NUM_REQ-1:0]                             l1_write_verified_o,
   output logic [NUM_REQ-1:0]                             l1_write_back_verified_o,
   output logic [MAIN_MEMORY_DATA_WIDTH-1:0]              l1_read_data_o,
   // L2 side
   output logic [ADDRESS_WIDTH-1:0]                       cache_L2_memory_address_o,
   output logic                                           read_from_L2_request_o,
   output logic                                           write_to_L2_request_o,
   output logic                                           write_back_to_L2_request_o,
   output logic [DATA_WIDTH-1:0]                          write_to_L2_data_o,
   output logic [MAIN_MEMORY_DATA_WIDTH-1:0]              write_back_to_L2_data_o,
   input  logic                                           L2_ready_i,
   input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]              L2_read_data_i,
   input  logic                                           write_to_L2_verified_i,
   input  logic                                           write_back_to_L2_verified_i,
   // Status
   output logic [$clog2(NUM_REQ)-1:0]                     grant_id_o,
   output logic                                           arb_busy_o,
   output logic                                           arb_timeout_error_o
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   // Control state
   arb_state_t                        state_q, state_d;
   l2_op_t                            op_q, op_d;
   logic [IDW-1:0]                    grant_q, grant_d;
   logic [IDW-1:0]                    rr_ptr_q, rr_ptr_d;
   logic [TW-1:0]                     cnt_q, cnt_d;
   // Latched request payload (drives the L2 side directly)
   logic [ADDRESS_WIDTH-1:0]          addr_q, addr_d;
   logic [DATA_WIDTH-1:0]             wdata_q, wdata_d;
   logic [MAIN_MEMORY_DATA_WIDTH-1:0] wbdata_q, wbdata_d;
   // Registered outputs
   logic                              rd_req_q, rd_req_d;
   logic                              wr_req_q, wr_req_d;
   logic                              wb_req_q, wb_req_d;
   logic [NUM_REQ-1:0]                rdy_q, rdy_d;
   logic [NUM_REQ-1:0]                wver_q, wver_d;
   logic [NUM_REQ-1:0]                wbver_q, wbver_d;
   logic [MAIN_MEMORY_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                              err_q, err_d;
   logic                              busy_q;

   // Combinational helpers
   logic [NUM_REQ-1:0]                active;
   logic [IDW-1:0]                    pick_id;
   logic                              pick_valid;
   l2_op_t                            pick_op;
   logic                              op_done;
   logic                              op_timeout;
   logic [NUM_REQ-1:0]                grant_onehot;

   assign active       = l1_read_request_i | l1_write_request_i | l1_write_back_request_i;
   assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
   assign op_timeout   = (TIMEOUT_CYCLES != 0) && (cnt_q == TW'(TIMEOUT_CYCLES - 1)) && !op_done;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_picker (
      .active_i (active),
      .rr_ptr_i (rr_ptr_q),
      .winner_o (pick_id),
      .valid_o  (pick_valid)
   );

   // Winner's operation: write-back beats write beats read
   always_comb begin
      pick_op = OP_READ;
      if (l1_write_back_request_i[pick_id]) begin
         pick_op = OP_WRITE_BACK;
      end else if (l1_write_request_i[pick_id]) begin
         pick_op = OP_WRITE;
      end
   end

   // Only the completion strobe matching the in-flight op counts
   always_comb begin
      op_done = 1'b0;
      case (op_q)
         OP_READ:       op_done = L2_ready_i;
         OP_WRITE:      op_done = write_to_L2_verified_i;
         OP_WRITE_BACK: op_done = write_back_to_L2_verified_i;
         default:       op_done = 1'b0;
      endcase
   end

   // Next-state: grant/latch in IDLE, wait for completion or timeout, release
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wbdata_d = wbdata_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = WAIT;
               grant_d = pick_id;
               op_d    = pick_op;
               addr_d  = l1_address_i[pick_id];
               cnt_d   = '0;
               if (pick_op == OP_WRITE) begin
                  wdata_d = l1_write_data_i[pick_id];
               end
               if (pick_op == OP_WRITE_BACK) begin
                  wbdata_d = l1_write_back_data_i[pick_id];
               end
            end
         end
         WAIT: begin
            if (op_done || op_timeout) begin
               state_d = RELEASE;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         RELEASE: begin
            state_d  = IDLE;
            rr_ptr_d = IDW'(rr_next(int'(grant_q), NUM_REQ));
         end
         default: state_d = IDLE;
      endcase
   end

   // Output next values: L2 request levels, response pulses, read data, error
   always_comb begin
      rd_req_d = 1'b0;
      wr_req_d = 1'b0;
      wb_req_d = 1'b0;
      rdy_d    = '0;
      wver_d   = '0;
      wbver_d  = '0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               rd_req_d = (pick_op == OP_READ);
               wr_req_d = (pick_op == OP_WRITE);
               wb_req_d = (pick_op == OP_WRITE_BACK);
            end
         end
         WAIT: begin
            if (op_done) begin
               case (op_q)
                  OP_READ: begin
                     rdy_d   = grant_onehot;
                     rdata_d = L2_read_data_i;
                  end
                  OP_WRITE:      wver_d  = grant_onehot;
                  OP_WRITE_BACK: wbver_d = grant_onehot;
                  default:       rdy_d   = '0;
               endcase
            end else if (op_timeout) begin
               err_d = 1'b1;
            end else begin
               rd_req_d = (op_q == OP_READ);
               wr_req_d = (op_q == OP_WRITE);
               wb_req_d = (op_q == OP_WRITE_BACK);
            end
         end
         default: begin
            rd_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= OP_READ;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wbdata_q <= '0;
         rd_req_q <= 1'b0;
         wr_req_q <= 1'b0;
         wb_req_q <= 1'b0;
         rdy_q    <= '0;
         wver_q   <= '0;
         wbver_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wbdata_q <= wbdata_d;
         rd_req_q <= rd_req_d;
         wr_req_q <= wr_req_d;
         wb_req_q <= wb_req_d;
         rdy_q    <= rdy_d;
         wver_q   <= wver_d;
         wbver_q  <= wbver_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         busy_q   <= (state_d != IDLE);
      end
   end

   assign l1_L2_ready_o              = rdy_q;
   assign l1_write_verified_o        = wver_q;
   assign l1_write_back_verified_o   = wbver_q;
   assign l1_read_data_o             = rdata_q;
   assign cache_L2_memory_address_o  = addr_q;
   assign read_from_L2_request_o     = rd_req_q;
   assign write_to_L2_request_o      = wr_req_q;
   assign write_back_to_L2_request_o = wb_req_q;
   assign write_to_L2_data_o         = wdata_q;
   assign write_back_to_L2_data_o    = wbdata_q;
   assign grant_id_o                 = grant_q;
   assign arb_busy_o                 = busy_q;
   assign arb_timeout_error_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_port_arbiter
//  Description : Self-checking bench for l2_port_arbiter. Scenario tasks plus
//                randomized request rounds checked against a transaction-level
//                round-robin model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_port_arbiter;
   import l2_port_arbiter_pkg::*;

   localparam int N   = 4;
   localparam int AW  = ADDRESS_WIDTH;
   localparam int DW  = DATA_WIDTH;
   localparam int MW  = MAIN_MEMORY_DATA_WIDTH;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [N-1:0]           rd_req, wr_req, wb_req;
   logic [N-1:0][AW-1:0]   addr;
   logic [N-1:0][DW-1:0]   wdata;
   logic [N-1:0][MW-1:0]   wbdata;
   logic [N-1:0]           l1_rdy, l1_wv, l1_wbv;
   logic [MW-1:0]          l1_rdata;
   logic [AW-1:0]          l2_addr;
   logic                   rd_o, wr_o, wb_o;
   logic [DW-1:0]          wdata_o;
   logic [MW-1:0]          wbdata_o;
   logic                   l2_ready, wr_ver, wb_ver;
   logic [MW-1:0]          l2_rdata;
   logic [1:0]             grant;
   logic                   busy, err;

   int                     vectors    = 0;
   int                     miscompares = 0;
   int                     model_ptr  = 0;
   logic [MW-1:0]          last_rdata = '0;

   l2_port_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk                         (clk),
      .rst_n                       (rst_n),
      .l1_read_request_i           (rd_req),
      .l1_write_request_i          (wr_req),
      .l1_write_back_request_i     (wb_req),
      .l1_address_i                (addr),
      .l1_write_data_i             (wdata),
      .l1_write_back_data_i        (wbdata),
      .l1_L2_ready_o               (l1_rdy),
      .l1_write_verified_o         (l1_wv),
      .l1_write_back_verified_o    (l1_wbv),
      .l1_read_data_o              (l1_rdata),
      .cache_L2_memory_address_o   (l2_addr),
      .read_from_L2_request_o      (rd_o),
      .write_to_L2_request_o       (wr_o),
      .write_back_to_L2_request_o  (wb_o),
      .write_to_L2_data_o          (wdata_o),
      .write_back_to_L2_data_o     (wbdata_o),
      .L2_ready_i                  (l2_ready),
      .L2_read_data_i              (l2_rdata),
      .write_to_L2_verified_i      (wr_ver),
      .write_back_to_L2_verified_i (wb_ver),
      .grant_id_o                  (grant),
      .arb_busy_o                  (busy),
      .arb_timeout_error_o         (err)
   );

   always #5 clk = ~clk;

   // Reference: first requester with any request bit set, scanning from model_ptr
   function automatic int model_pick(input logic [N-1:0] act);
      for (int k = 0; k < N; k++) begin
         if (act[(model_ptr + k) % N]) return (model_ptr + k) % N;
      end
      return -1;
   endfunction

   // Reference: expected {write_back, write, read} request bits for a requester
   function automatic logic [2:0] model_op(input int id);
      if (wb_req[id]) return 3'b100;
      if (wr_req[id]) return 3'b010;
      return 3'b001;
   endfunction

   function automatic logic [MW-1:0] rand_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic clear_inputs();
      rd_req = '0; wr_req = '0; wb_req = '0;
      addr = '0; wdata = '0; wbdata = '0;
      l2_ready = 1'b0; wr_ver = 1'b0; wb_ver = 1'b0; l2_rdata = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      model_ptr  = 0;
      last_rdata = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Acts as every L1 and as the L2: serves ntx transactions, checking each
   // grant against the round-robin model, the held request, and the response.
   task automatic run_transactions(input int ntx, input bit noise, input int min_delay);
      int         served, phase, delay, cyc, exp_id;
      logic [2:0] exp_op;
      logic [N-1:0] onehot;
      logic [MW-1:0] rd_exp;
      served = 0; phase = 0; delay = 0; cyc = 0; exp_id = 0;
      exp_op = 3'b001; onehot = '0; rd_exp = '0;
      while (served < ntx && cyc < 400) begin
         @(negedge clk);
         cyc++;
         l2_ready = 1'b0; wr_ver = 1'b0; wb_ver = 1'b0;
         if (phase == 2) begin
            vectors++;
            if (l1_rdy !== ((exp_op == 3'b001) ? onehot : '0) ||
                l1_wv  !== ((exp_op == 3'b010) ? onehot : '0) ||
                l1_wbv !== ((exp_op == 3'b100) ? onehot : '0) ||
                {wb_o, wr_o, rd_o} !== 3'b000 || l1_rdata !== last_rdata ||
                grant !== exp_id[1:0] || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL response: got id=%0d rdy=%b wv=%b wbv=%b req=%b busy=%b rdata=%h, want id=%0d op=%b rdata=%h",
                        grant, l1_rdy, l1_wv, l1_wbv, {wb_o, wr_o, rd_o}, busy, l1_rdata, exp_id, exp_op, last_rdata);
            end
            rd_req[exp_id] = 1'b0; wr_req[exp_id] = 1'b0; wb_req[exp_id] = 1'b0;
            model_ptr = (exp_id + 1) % N;
            served++;
            phase = 0;
         end else if (phase == 0 && {wb_o, wr_o, rd_o} !== 3'b000) begin
            exp_id = model_pick(rd_req | wr_req | wb_req);
            if (exp_id < 0) exp_id = 0;
            exp_op = model_op(exp_id);
            onehot = '0;
            onehot[exp_id] = 1'b1;
            vectors++;
            if (grant !== exp_id[1:0] || {wb_o, wr_o, rd_o} !== exp_op || l2_addr !== addr[exp_id] ||
                (exp_op == 3'b010 && wdata_o !== wdata[exp_id]) ||
                (exp_op == 3'b100 && wbdata_o !== wbdata[exp_id])) begin
               miscompares++;
               $display("FAIL grant: got id=%0d req=%b addr=%h wd=%h wbd=%h, want id=%0d req=%b addr=%h wd=%h wbd=%h",
                        grant, {wb_o, wr_o, rd_o}, l2_addr, wdata_o, wbdata_o,
                        exp_id, exp_op, addr[exp_id], wdata[exp_id], wbdata[exp_id]);
            end
            delay = $urandom_range(min_delay, min_delay + 4);
            phase = 1;
         end
         if (phase == 1) begin
            vectors++;
            if ({wb_o, wr_o, rd_o} !== exp_op || l2_addr !== addr[exp_id] || grant !== exp_id[1:0] ||
                busy !== 1'b1 || (l1_rdy | l1_wv | l1_wbv) !== '0) begin
               miscompares++;
               $display("FAIL hold: got id=%0d req=%b addr=%h busy=%b pulses=%b, want id=%0d req=%b addr=%h busy=1 pulses=0",
                        grant, {wb_o, wr_o, rd_o}, l2_addr, busy, l1_rdy | l1_wv | l1_wbv, exp_id, exp_op, addr[exp_id]);
            end
            if (noise) begin
               l2_rdata = rand_block();
               if (exp_op != 3'b001) l2_ready = 1'($urandom_range(0, 1));
               if (exp_op != 3'b010) wr_ver   = 1'($urandom_range(0, 1));
               if (exp_op != 3'b100) wb_ver   = 1'($urandom_range(0, 1));
            end
            if (delay == 0) begin
               if (exp_op == 3'b001) begin
                  rd_exp     = rand_block();
                  l2_rdata   = rd_exp;
                  l2_ready   = 1'b1;
                  last_rdata = rd_exp;
               end else if (exp_op == 3'b010) begin
                  wr_ver = 1'b1;
               end else begin
                  wb_ver = 1'b1;
               end
               phase = 2;
            end else begin
               delay--;
            end
         end
      end
      l2_ready = 1'b0; wr_ver = 1'b0; wb_ver = 1'b0;
      vectors++;
      if (served !== ntx) begin
         miscompares++;
         $display("FAIL serve_count: got %0d transactions, want %0d", served, ntx);
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      vectors++;
      if ({l1_rdy, l1_wv, l1_wbv, rd_o, wr_o, wb_o, busy, err, grant} !== '0 ||
          l1_rdata !== '0 || l2_addr !== '0 || wdata_o !== '0 || wbdata_o !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got req=%b pulses=%b busy=%b err=%b grant=%0d addr=%h, want all zero",
                  {wb_o, wr_o, rd_o}, l1_rdy | l1_wv | l1_wbv, busy, err, grant, l2_addr);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_ptr = 0;
      last_rdata = '0;
   endtask

   task automatic test_single_read();
      logic [MW-1:0] d;
      d = rand_block();
      @(negedge clk);
      rd_req[2] = 1'b1;
      addr[2]   = 32'h8000_0040;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         vectors++;
         if (rd_o !== 1'b1 || {wr_o, wb_o} !== 2'b00 || l2_addr !== 32'h8000_0040 || l1_rdy !== 4'b0000 || grant !== 2'd2) begin
            miscompares++;
            $display("FAIL single_read_wait c%0d: got rd=%b addr=%h rdy=%b grant=%0d, want rd=1 addr=80000040 rdy=0000 grant=2",
                     c, rd_o, l2_addr, l1_rdy, grant);
         end
         if (c == 3) begin
            l2_ready = 1'b1;
            l2_rdata = d;
         end
      end
      @(negedge clk);
      l2_ready = 1'b0;
      l2_rdata = rand_block();
      vectors++;
      if (l1_rdy !== 4'b0100 || l1_rdata !== d || rd_o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_read_resp: got rdy=%b rd=%b data=%h, want rdy=0100 rd=0 data=%h", l1_rdy, rd_o, l1_rdata, d);
      end
      rd_req[2] = 1'b0;
      @(negedge clk);
      vectors++;
      if (l1_rdy !== 4'b0000 || l1_rdata !== d || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_read_after: got rdy=%b busy=%b data=%h, want rdy=0000 busy=0 data=%h", l1_rdy, busy, l1_rdata, d);
      end
      model_ptr  = 3;
      last_rdata = d;
   endtask

   task automatic test_all_four();
      apply_reset();
      for (int i = 0; i < N; i++) begin
         rd_req[i] = 1'b1;
         addr[i]   = $urandom;
      end
      run_transactions(4, 1'b0, 0);
   endtask

   task automatic test_wb_priority();
      wb_req[1] = 1'b1;
      wr_req[1] = 1'b1;
      addr[1]   = $urandom;
      wdata[1]  = $urandom;
      wbdata[1] = rand_block();
      run_transactions(1, 1'b0, 0);
      wr_req[1] = 1'b1;
      wdata[1]  = $urandom;
      run_transactions(1, 1'b0, 0);
   endtask

   task automatic test_ignore_other_completion();
      rd_req[0] = 1'b1;
      addr[0]   = $urandom;
      run_transactions(1, 1'b1, 2);
   endtask

   task automatic test_random();
      for (int r = 0; r < 25; r++) begin
         logic [N-1:0] sel;
         logic [2:0]   ops;
         int           cnt;
         sel = N'($urandom_range(1, (1 << N) - 1));
         cnt = 0;
         for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
               ops       = 3'($urandom_range(1, 7));
               rd_req[i] = ops[0];
               wr_req[i] = ops[1];
               wb_req[i] = ops[2];
               addr[i]   = $urandom;
               wdata[i]  = $urandom;
               wbdata[i] = rand_block();
               cnt++;
            end
         end
         run_transactions(cnt, 1'b1, 0);
      end
   endtask

   task automatic test_timeout();
      int cyc, hi;
      @(negedge clk);
      rd_req[1] = 1'b1;
      addr[1]   = $urandom;
      cyc = 0;
      while (rd_o !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (rd_o !== 1'b1 || grant !== 2'd1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_grant: got rd=%b grant=%0d err=%b, want rd=1 grant=1 err=0", rd_o, grant, err);
      end
      rd_req[3] = 1'b1;
      addr[3]   = $urandom;
      hi = 0;
      while (rd_o === 1'b1 && hi < 40) begin
         hi++;
         @(negedge clk);
      end
      vectors++;
      if (hi !== 8) begin
         miscompares++;
         $display("FAIL timeout_length: got %0d request cycles, want 8", hi);
      end
      vectors++;
      if (err !== 1'b1 || (l1_rdy | l1_wv | l1_wbv) !== '0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_release: got err=%b pulses=%b busy=%b, want err=1 pulses=0 busy=1",
                  err, l1_rdy | l1_wv | l1_wbv, busy);
      end
      rd_req[1] = 1'b0;
      model_ptr = 2;
      run_transactions(1, 1'b0, 0);
      vectors++;
      if (err !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_sticky: got err=%b, want 1", err);
      end
   endtask

   task automatic test_reset_mid_wait();
      int cyc;
      rd_req[1] = 1'b1;
      addr[1]   = $urandom;
      run_transactions(1, 1'b0, 0);
      @(negedge clk);
      rd_req[2] = 1'b1;
      addr[2]   = $urandom;
      cyc = 0;
      while (rd_o !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({l1_rdy, l1_wv, l1_wbv, rd_o, wr_o, wb_o, busy, err, grant} !== '0 ||
          l1_rdata !== '0 || l2_addr !== '0 || wdata_o !== '0 || wbdata_o !== '0) begin
         miscompares++;
         $display("FAIL async_reset: got req=%b busy=%b err=%b grant=%0d addr=%h rdata=%h, want all zero",
                  {wb_o, wr_o, rd_o}, busy, err, grant, l2_addr, l1_rdata);
      end
      clear_inputs();
      @(negedge clk);
      rst_n      = 1'b1;
      model_ptr  = 0;
      last_rdata = '0;
      rd_req[0]  = 1'b1; addr[0] = $urandom;
      rd_req[3]  = 1'b1; addr[3] = $urandom;
      run_transactions(2, 1'b0, 0);
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_clears_error: got err=%b, want 0", err);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      clear_inputs();
      test_reset();
      test_single_read();
      test_all_four();
      test_wb_priority();
      test_ignore_other_completion();
      test_random();
      test_timeout();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 request port between NUM_REQ L1 cache FSMs (L1a..L1d, one per processor ID).
- Round-robin grant; one L2 transaction (read, word write, or block write-back) in flight at a time.
- Latches the winner's address/data, holds the L2 request until the matching L2 completion, then pulses the completion back to the granted L1 only.
- Sits between the L1 cache FSM outputs and the L2 cache FSM inputs.

Parameters:
NUM_REQ, 4, number of L1 requesters (IDs 0..NUM_REQ-1)
TIMEOUT_CYCLES, 1024, max cycles in WAIT before abort; 0 disables the timeout

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low; state cleared while 0
l1_read_request  input  NUM_REQ  per-L1 read_from_L2_request
l1_write_request  input  NUM_REQ  per-L1 write_to_L2_request
l1_write_back_request  input  NUM_REQ  per-L1 write_back_to_L2_request
l1_address  input  NUM_REQ x ADDRESS_WIDTH  per-L1 cache_L2_memory_address
l1_write_data  input  NUM_REQ x DATA_WIDTH  per-L1 word write data
l1_write_back_data  input  NUM_REQ x MAIN_MEMORY_DATA_WIDTH  per-L1 evicted block
l1_L2_ready  output  NUM_REQ  one-hot read-complete pulse
l1_write_verified  output  NUM_REQ  one-hot write-complete pulse
l1_write_back_verified  output  NUM_REQ  one-hot write-back-complete pulse
l1_read_data  output  MAIN_MEMORY_DATA_WIDTH  block from L2, valid with l1_L2_ready
cache_L2_memory_address  output  ADDRESS_WIDTH  to L2
read_from_L2_request  output  1  to L2
write_to_L2_request  output  1  to L2
write_back_to_L2_request  output  1  to L2
write_to_L2_data  output  DATA_WIDTH  to L2
write_back_to_L2_data  output  MAIN_MEMORY_DATA_WIDTH  to L2
L2_ready  input  1  L2 read complete
L2_read_data  input  MAIN_MEMORY_DATA_WIDTH  L2 block, valid with L2_ready
write_to_L2_verified  input  1  L2 write complete
write_back_to_L2_verified  input  1  L2 write-back complete
grant_id  output  $clog2(NUM_REQ)  current/last granted requester
arb_busy  output  1  high in WAIT and RELEASE
arb_timeout_error  output  1  sticky; set on timeout abort

Behaviour:
- Reset (reset==0, async): state IDLE, rr_ptr=0, every output 0, timeout counter 0, arb_timeout_error=0.
- All outputs registered.
- A requester is active if any of its three request bits is high.
- Per-requester op priority: write_back > write > read.
- IDLE:
  - Scan starts at rr_ptr, wrapping modulo NUM_REQ; the first active requester wins.
  - At the edge: latch grant_id, op, address, and the matching data; go to WAIT.
  - No active requester: stay in IDLE.
- WAIT:
  - Drive exactly one L2 request bit for the latched op, plus the latched address/data; hold them stable.
  - Completion input per op: read=L2_ready, write=write_to_L2_verified, write_back=write_back_to_L2_verified. Completion inputs for other ops are ignored.
  - On completion at edge k: in cycle k+1 the L2 request is 0, the matching one-hot response bit for grant_id is 1, and l1_read_data=L2_read_data captured at edge k (reads only); go to RELEASE.
  - Requester dropping its request during WAIT has no effect; the transaction completes and the response pulse is still issued.
- Latency: request seen in IDLE at cycle 0 -> L2 request high in cycle 1 -> completion sampled at cycle k -> response pulse in cycle k+1 only.
- RELEASE:
  - Lasts one cycle; response pulse is high in this cycle.
  - rr_ptr <= (grant_id+1) mod NUM_REQ; go to IDLE. New grants are decided only in IDLE.
  - The L1 deasserts its level request in this cycle, so no stale re-grant occurs.
- Timeout:
  - Counter runs in WAIT, cleared on entry.
  - When it reaches TIMEOUT_CYCLES (nonzero): drop the L2 request, set arb_timeout_error, go to RELEASE with no response pulse; rr_ptr still advances.
- Simultaneous requests: grant order strictly round-robin; a requester waits at most NUM_REQ-1 transactions.
- l1_read_data holds its last value until the next read completion.

Decomposition:
- cache_config package: NUM_REQ default and TIMEOUT_CYCLES default constants, arb_state_t enum {IDLE, WAIT, RELEASE}, l2_op_t enum {OP_READ, OP_WRITE, OP_WRITE_BACK}.
- Existing ADDRESS_WIDTH, DATA_WIDTH, MAIN_MEMORY_DATA_WIDTH come from cache_config and main_memory_config.
- One sub-module: rr_priority_picker (combinational; inputs active vector and rr_ptr; outputs winner index and valid).

Test Plan:
- Single read: L1 2 read addr 0x8000_0040; L2_ready with data D 3 cycles after request -> read_from_L2_request high cycles 1-3, l1_L2_ready=4'b0100 and l1_read_data=D in cycle 4 only.
- All four L1s request reads in the same cycle from reset -> grants in order 0,1,2,3; no L2 request overlap; each response one-hot to the correct L1.
- L1 1 raises write_back and write together -> write-back issued first with its block; write granted in a later IDLE after L1 1 re-requests.
- write_to_L2_verified pulses during a read transaction -> ignored; arbiter stays in WAIT until L2_ready.
- TIMEOUT_CYCLES=8 with no L2 completion -> request drops after 8 WAIT cycles, arb_timeout_error=1 and stays 1, no response pulse, next requester granted.
- reset driven 0 mid-WAIT -> all outputs 0 immediately (asynchronous); after release, IDLE with rr_ptr=0.
